// File: rtl/crg_domain_seq.sv
// rtl/crg_domain_seq.sv - per-channel power-domain clock-gate / reset sequencer
//
// Purpose: for each of CH_NUM channels, synchronise an asynchronous enable
// request and sequence the clock-gate enable and reset release so that the
// clock always runs ON_DLY cycles before reset lifts, and reset is held
// OFF_DLY cycles before the clock stops. Per-channel and global soft resets
// hold the channel reset low for SWRST_LEN cycles with the clock running.
//
// Ports:
//   clk        always-on clock, all logic on posedge
//   rst        asynchronous active-high reset
//   scan_mode  scan bypass: forces ckgt_en high and rst_n_o to scan_rstn
//   scan_rstn  reset value driven onto every rst_n_o while in scan
//   en_req     per-channel enable request, asynchronous to clk
//   sw_rst     per-channel soft-reset request, synchronous
//   glb_swrst  global soft-reset request, synchronous, hits every channel
//   ckgt_en    per-channel clock-gate enable
//   rst_n_o    per-channel active-low reset
//   ready      per-channel "in RUN" flag
//   busy       any channel waking, soft-resetting or going to sleep
module crg_domain_seq #(
  parameter int CH_NUM      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ON_DLY      = 4,
  parameter int OFF_DLY     = 2,
  parameter int SWRST_LEN   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_mode,
  input  logic              scan_rstn,
  input  logic [CH_NUM-1:0] en_req,
  input  logic [CH_NUM-1:0] sw_rst,
  input  logic              glb_swrst,
  output logic [CH_NUM-1:0] ckgt_en,
  output logic [CH_NUM-1:0] rst_n_o,
  output logic [CH_NUM-1:0] ready,
  output logic              busy
);

  localparam int MAX_ON_OFF = (ON_DLY > OFF_DLY) ? ON_DLY : OFF_DLY;
  localparam int MAX_DLY    = (MAX_ON_OFF > SWRST_LEN) ? MAX_ON_OFF : SWRST_LEN;
  localparam int CW         = $clog2(MAX_DLY + 1);

  localparam logic [CW-1:0] ON_LAST    = CW'(ON_DLY - 1);
  localparam logic [CW-1:0] OFF_LAST   = CW'(OFF_DLY - 1);
  localparam logic [CW-1:0] SWRST_LAST = CW'(SWRST_LEN - 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_WAKE,
    S_RUN,
    S_SWRST,
    S_SLEEP
  } state_t;

  // Request synchroniser: stage 0 samples the asynchronous en_req.
  logic [CH_NUM-1:0] sync_q [SYNC_STAGES];
  logic [CH_NUM-1:0] req_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= en_req;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  logic [CH_NUM-1:0] fsm_ckgt;
  logic [CH_NUM-1:0] fsm_rstn;
  logic [CH_NUM-1:0] fsm_busy;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            swrst;

    assign swrst = sw_rst[i] | glb_swrst;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= S_OFF;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        S_OFF: begin
          if (req_s[i]) begin
            state_d = S_WAKE;
            cnt_d   = '0;
          end
        end
        // Abort beats everything so reset is never released on a request
        // that has already gone away; a soft reset restarts the wake-up
        // delay rather than letting reset lift underneath it.
        S_WAKE: begin
          if (!req_s[i]) begin
            state_d = S_SLEEP;
            cnt_d   = '0;
          end else if (swrst) begin
            cnt_d = '0;
          end else if (cnt_q == ON_LAST) begin
            state_d = S_RUN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_RUN: begin
          if (swrst) begin
            state_d = S_SWRST;
            cnt_d   = '0;
          end else if (!req_s[i]) begin
            state_d = S_SLEEP;
            cnt_d   = '0;
          end
        end
        S_SWRST: begin
          if (swrst) begin
            cnt_d = '0;
          end else if (cnt_q == SWRST_LAST) begin
            state_d = req_s[i] ? S_RUN : S_SLEEP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        // SLEEP always runs to completion so the reset-before-clock-off
        // guarantee holds even if the request comes straight back.
        S_SLEEP: begin
          if (cnt_q == OFF_LAST) begin
            state_d = S_OFF;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_OFF;
          cnt_d   = '0;
        end
      endcase
    end

    assign fsm_ckgt[i] = (state_q != S_OFF);
    assign fsm_rstn[i] = (state_q == S_RUN);
    assign fsm_busy[i] = (state_q == S_WAKE) || (state_q == S_SWRST) || (state_q == S_SLEEP);
  end

  assign ckgt_en = scan_mode ? {CH_NUM{1'b1}} : fsm_ckgt;
  assign rst_n_o = scan_mode ? {CH_NUM{scan_rstn}} : fsm_rstn;
  assign ready   = fsm_rstn;
  assign busy    = |fsm_busy;

endmodule

// File: tb/tb_crg_domain_seq.sv
// tb/tb_crg_domain_seq.sv - self-checking bench for crg_domain_seq
module tb_crg_domain_seq;
  localparam int CH   = 4;
  localparam int SS   = 2;
  localparam int ON   = 4;
  localparam int OFFD = 2;
  localparam int SWL  = 8;

  localparam int P_OFF   = 0;
  localparam int P_WAKE  = 1;
  localparam int P_RUN   = 2;
  localparam int P_SWRST = 3;
  localparam int P_SLEEP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          scan_mode;
  logic          scan_rstn;
  logic [CH-1:0] en_req;
  logic [CH-1:0] sw_rst;
  logic          glb_swrst;
  logic [CH-1:0] ckgt_en;
  logic [CH-1:0] rst_n_o;
  logic [CH-1:0] ready;
  logic          busy;

  int total = 0;
  int bad   = 0;

  // Reference model: each channel is in a phase with a number of cycles
  // left in it; the synchroniser is an en_req history looked up SS edges back.
  int            ph   [CH];
  int            left [CH];
  logic [CH-1:0] hist [$];

  always #5 clk = ~clk;

  crg_domain_seq #(
    .CH_NUM(CH), .SYNC_STAGES(SS), .ON_DLY(ON), .OFF_DLY(OFFD), .SWRST_LEN(SWL)
  ) dut (
    .clk(clk), .rst(rst), .scan_mode(scan_mode), .scan_rstn(scan_rstn),
    .en_req(en_req), .sw_rst(sw_rst), .glb_swrst(glb_swrst),
    .ckgt_en(ckgt_en), .rst_n_o(rst_n_o), .ready(ready), .busy(busy)
  );

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin
      ph[i]   = P_OFF;
      left[i] = 0;
    end
    hist.delete();
  endfunction

  function automatic void model_step(input logic [CH-1:0] e, input logic [CH-1:0] s, input logic g);
    logic [CH-1:0] reqv;
    logic          sw;
    reqv = (hist.size() >= SS) ? hist[hist.size()-SS] : '0;
    hist.push_back(e);
    if (hist.size() > 8) void'(hist.pop_front());
    for (int i = 0; i < CH; i++) begin
      sw = s[i] | g;
      case (ph[i])
        P_OFF:   if (reqv[i]) begin ph[i] = P_WAKE; left[i] = ON; end
        P_WAKE: begin
          if (!reqv[i]) begin ph[i] = P_SLEEP; left[i] = OFFD; end
          else if (sw) left[i] = ON;
          else begin
            left[i]--;
            if (left[i] == 0) ph[i] = P_RUN;
          end
        end
        P_RUN: begin
          if (sw) begin ph[i] = P_SWRST; left[i] = SWL; end
          else if (!reqv[i]) begin ph[i] = P_SLEEP; left[i] = OFFD; end
        end
        P_SWRST: begin
          if (sw) left[i] = SWL;
          else begin
            left[i]--;
            if (left[i] == 0) begin
              if (reqv[i]) ph[i] = P_RUN;
              else begin ph[i] = P_SLEEP; left[i] = OFFD; end
            end
          end
        end
        default: begin
          left[i]--;
          if (left[i] == 0) ph[i] = P_OFF;
        end
      endcase
    end
  endfunction

  // {busy, ready, rst_n_o, ckgt_en} predicted by the model.
  function automatic logic [3*CH:0] exp_vec();
    logic [CH-1:0] c, r, y;
    logic          b;
    c = '0; r = '0; y = '0; b = 1'b0;
    for (int i = 0; i < CH; i++) begin
      c[i] = (ph[i] != P_OFF);
      y[i] = (ph[i] == P_RUN);
      b    = b | (ph[i] == P_WAKE) | (ph[i] == P_SWRST) | (ph[i] == P_SLEEP);
    end
    r = y;
    if (scan_mode) begin
      c = '1;
      r = {CH{scan_rstn}};
    end
    return {b, y, r, c};
  endfunction

  task automatic tick();
    logic [CH-1:0] e, s;
    logic          g;
    e = en_req; s = sw_rst; g = glb_swrst;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(e, s, g);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en_req = '0; sw_rst = '0; glb_swrst = 1'b0;
    scan_mode = 1'b0; scan_rstn = 1'b0;
    model_reset();
    repeat (2) tick();
    total++;
    if ({busy, ready, rst_n_o, ckgt_en} !== 13'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", {busy, ready, rst_n_o, ckgt_en});
    end
    rst = 1'b0;
    tick();
    total++;
    if ({busy, ready, rst_n_o, ckgt_en} !== exp_vec()) begin
      bad++;
      $display("FAIL reset_release: got %h want %h", {busy, ready, rst_n_o, ckgt_en}, exp_vec());
    end
  endtask

  task automatic test_power_up();
    en_req = 4'b0001;
    for (int k = 1; k <= 10; k++) begin
      tick();
      total++;
      if ({busy, ready, rst_n_o, ckgt_en} !== exp_vec()) begin
        bad++;
        $display("FAIL power_up_model k=%0d: got %h want %h", k, {busy, ready, rst_n_o, ckgt_en}, exp_vec());
      end
      if (k == 2 || k == 3) begin
        total++;
        if (ckgt_en[0] !== (k >= 3)) begin
          bad++;
          $display("FAIL power_up_ckgt k=%0d: got %b want %b", k, ckgt_en[0], (k >= 3));
        end
      end
      if (k == 6 || k == 7) begin
        total++;
        if ({rst_n_o[0], ready[0]} !== {2{k >= 7}}) begin
          bad++;
          $display("FAIL power_up_rstn k=%0d: got %b%b want %b", k, rst_n_o[0], ready[0], (k >= 7));
        end
      end
    end
    total++;
    if ({ckgt_en[3:1], rst_n_o[3:1], ready[3:1]} !== 9'h0) begin
      bad++;
      $display("FAIL power_up_others: got %h want 0", {ckgt_en[3:1], rst_n_o[3:1], ready[3:1]});
    end
  endtask

  task automatic test_power_down();
    en_req = 4'b0011;
    repeat (10) tick();
    en_req = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if ({busy, ready, rst_n_o, ckgt_en} !== exp_vec()) begin
        bad++;
        $display("FAIL power_down_model k=%0d: got %h want %h", k, {busy, ready, rst_n_o, ckgt_en}, exp_vec());
      end
      total++;
      if ({rst_n_o[1], ckgt_en[1], busy} !== {(k < 3), (k < 5), (k == 3 || k == 4)}) begin
        bad++;
        $display("FAIL power_down_seq k=%0d: got rstn/ckgt/busy=%b%b%b want %b%b%b", k,
                 rst_n_o[1], ckgt_en[1], busy, (k < 3), (k < 5), (k == 3 || k == 4));
      end
    end
  endtask

  task automatic test_swrst();
    int lowcnt, clkoff;
    en_req = 4'b0101;
    repeat (10) tick();
    for (int pass = 0; pass < 2; pass++) begin
      lowcnt = 0; clkoff = 0;
      sw_rst[2] = 1'b1;
      for (int k = 1; k <= 25; k++) begin
        tick();
        if (k == 1) sw_rst = '0;
        if (pass == 1 && k == 5) sw_rst[2] = 1'b1;
        if (pass == 1 && k == 6) sw_rst = '0;
        total++;
        if ({busy, ready, rst_n_o, ckgt_en} !== exp_vec()) begin
          bad++;
          $display("FAIL swrst_model p=%0d k=%0d: got %h want %h", pass, k, {busy, ready, rst_n_o, ckgt_en}, exp_vec());
        end
        if (!rst_n_o[2]) lowcnt++;
        if (!ckgt_en[2]) clkoff++;
      end
      total++;
      if (lowcnt != ((pass == 0) ? 8 : 13) || clkoff != 0 || ready[2] !== 1'b1) begin
        bad++;
        $display("FAIL swrst_len p=%0d: got low=%0d clkoff=%0d ready=%b want low=%0d clkoff=0 ready=1",
                 pass, lowcnt, clkoff, ready[2], (pass == 0) ? 8 : 13);
      end
    end
  endtask

  task automatic test_glb_swrst();
    int lowcnt;
    en_req = 4'b1111;
    repeat (10) tick();
    lowcnt = 0;
    glb_swrst = 1'b1;
    en_req[3] = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      tick();
      glb_swrst = 1'b0;
      total++;
      if ({busy, ready, rst_n_o, ckgt_en} !== exp_vec()) begin
        bad++;
        $display("FAIL glb_swrst_model k=%0d: got %h want %h", k, {busy, ready, rst_n_o, ckgt_en}, exp_vec());
      end
      if (!rst_n_o[0]) lowcnt++;
    end
    total++;
    if (lowcnt != 8 || ready !== 4'b0111 || ckgt_en !== 4'b0111 || busy !== 1'b0) begin
      bad++;
      $display("FAIL glb_swrst_end: got low=%0d ready=%b ckgt=%b busy=%b want 8 0111 0111 0",
               lowcnt, ready, ckgt_en, busy);
    end
  endtask

  task automatic test_wake_abort();
    int rises;
    apply_reset();
    en_req = 4'b0001;
    rises = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 4) en_req[0] = 1'b0;
      if (k == 5) en_req[0] = 1'b1;
      total++;
      if ({busy, ready, rst_n_o, ckgt_en} !== exp_vec()) begin
        bad++;
        $display("FAIL wake_abort_model k=%0d: got %h want %h", k, {busy, ready, rst_n_o, ckgt_en}, exp_vec());
      end
      if (k <= 12 && rst_n_o[0]) rises++;
      if (k == 3 || k == 8 || k == 9 || k == 10) begin
        total++;
        if (ckgt_en[0] !== (k != 9)) begin
          bad++;
          $display("FAIL wake_abort_ckgt k=%0d: got %b want %b", k, ckgt_en[0], (k != 9));
        end
      end
    end
    total++;
    if (rises != 0 || rst_n_o[0] !== 1'b1) begin
      bad++;
      $display("FAIL wake_abort_rstn: got early_high=%0d final=%b want 0 1", rises, rst_n_o[0]);
    end
  endtask

  task automatic test_scan();
    scan_mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      scan_rstn = k[0];
      #1;
      total++;
      if (ckgt_en !== 4'hF || rst_n_o !== {CH{k[0]}}) begin
        bad++;
        $display("FAIL scan_force k=%0d: got ckgt=%h rstn=%h want F %h", k, ckgt_en, rst_n_o, {CH{k[0]}});
      end
      tick();
    end
    scan_mode = 1'b0;
    #1;
    total++;
    if ({busy, ready, rst_n_o, ckgt_en} !== exp_vec()) begin
      bad++;
      $display("FAIL scan_exit: got %h want %h", {busy, ready, rst_n_o, ckgt_en}, exp_vec());
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    en_req = 4'b0001;
    repeat (4) tick();
    total++;
    if (ckgt_en[0] !== 1'b1 || rst_n_o[0] !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_wake: got ckgt=%b rstn=%b want 1 0", ckgt_en[0], rst_n_o[0]);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({ckgt_en, rst_n_o, ready, busy} !== 13'h0) begin
      bad++;
      $display("FAIL mid_reset_async: got %h want 0", {ckgt_en, rst_n_o, ready, busy});
    end
    model_reset();
    tick();
    rst = 1'b0;
    en_req = '0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 39) == 0) en_req[$urandom_range(0, CH-1)] ^= 1'b1;
      sw_rst = '0;
      if ($urandom_range(0, 29) == 0) sw_rst[$urandom_range(0, CH-1)] = 1'b1;
      glb_swrst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 199) == 0) scan_mode = ~scan_mode;
      if ($urandom_range(0, 9) == 0) scan_rstn = 1'($urandom_range(0, 1));
      tick();
      total++;
      if ({busy, ready, rst_n_o, ckgt_en} !== exp_vec()) begin
        bad++;
        $display("FAIL random k=%0d: got %h want %h", k, {busy, ready, rst_n_o, ckgt_en}, exp_vec());
      end
    end
    sw_rst = '0; glb_swrst = 1'b0; scan_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_power_down();
    test_swrst();
    test_glb_swrst();
    test_wake_abort();
    test_scan();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
